inst_fifo: RTL and testbench
============================

Name: inst_fifo

Overview:
Decoupling instruction buffer between the IF1 stage register and decode.
- Write side: accepts one fetch packet per cycle (1 or 2 instructions, 8-byte aligned pair) over a valid/allowin handshake.
- Write side also returns the back-pressure hints space_ok and nearly_full, which the fetch side uses to throttle in-flight icache requests.
- Read side: presents up to two in-order instructions per cycle to decode and pops what decode accepts.

Parameters:
DEPTH, 8, instruction slots (power of 2, >= 4)
SPACE_TH, 6, free-slot count at or above which space_ok is asserted (2 <= SPACE_TH <= DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  discard all contents
in_valid  in  1  packet offered
in_allowin  out  1  at least 2 free slots
in_pc  in  32  packet PC
in_pc_next  in  32  predicted next PC
in_pc_taken  in  1  prediction taken
in_inst0  in  32  first instruction
in_inst1  in  32  second instruction (ignored when in_pc[2]=1)
in_badv  in  32  fetch bad VA
in_exception  in  7  exception code
in_excp_flag  in  2  nonzero = fetch exception
space_ok  out  1  free >= SPACE_TH
nearly_full  out  1  2 <= free < SPACE_TH
id_allowin  in  1  decode accepts all presented valid slots
out_valid0, out_valid1  out  1 each  slot valid
out_pc0, out_pc1  out  32 each  slot PC
out_pc_next0, out_pc_next1  out  32 each  slot predicted next PC
out_taken0, out_taken1  out  1 each  slot prediction taken
out_inst0, out_inst1  out  32 each  slot instruction
out_badv0, out_badv1  out  32 each
out_exception0, out_exception1  out  7 each
out_excp_flag0, out_excp_flag1  out  2 each

Behaviour:
Storage and reset
- Circular buffer of DEPTH slots.
- Each slot holds: pc, pc_next, taken, inst, badv, exception, excp_flag.
- Pointers: head and tail, each log2(DEPTH) bits, natural wrap. count is log2(DEPTH)+1 bits. free = DEPTH - count.
- Reset (async) and flush (sync): head = tail = count = 0.
- Out of reset: all out_valid* = 0, space_ok = 1, nearly_full = 0, in_allowin = 1.
- Slot contents reset to pc 0, inst INST_NOP (0x0340_0000), all other fields 0.
- flush overrides push and pop in the same cycle.

Push (in_valid && in_allowin), written at the clock edge
- Slot count n:
  - n = 1 if in_pc[2] = 1 or in_excp_flag != 0;
  - otherwise n = 2.
- Slot A (tail) gets:
  - pc = in_pc;
  - inst = in_pc[2] ? in_inst1 : in_inst0;
  - excp fields from the packet.
- Slot B (tail+1, only when n = 2) gets:
  - pc = in_pc + 4;
  - inst = in_inst1;
  - excp fields cleared.
- The last written slot gets pc_next = in_pc_next and taken = in_pc_taken.
- A non-last slot gets pc_next = its pc + 4 and taken = 0.
- tail += n.

Back-pressure flags
- in_allowin = (free >= 2).
- space_ok = (free >= SPACE_TH).
- nearly_full = (free >= 2) && (free < SPACE_TH).
- All three are computed from the registered count only; a same-cycle pop does not raise them.

Read side (combinational from storage)
- out_valid0 = count >= 1.
- out_valid1 = count >= 2 && head slot excp_flag == 0. An excepting instruction always issues alone in slot 0.
- Pop: when id_allowin, pop m = out_valid0 + out_valid1; head += m.
- Slot 0 always shows the head slot; slot 1 always shows head+1.

Count update
- Simultaneous push and pop: count_next = count + n - m.
- The fill level never exceeds DEPTH, by construction of in_allowin.
- Head and tail wrap from DEPTH-1 to 0 seamlessly. A 2-slot push at tail = DEPTH-1 writes slots DEPTH-1 and 0.

Test Plan:
- Reset:
  - assert rst mid-operation with count = 5 -> out_valid0 = 0 immediately (async);
  - after release: in_allowin = 1, space_ok = 1, nearly_full = 0.
- Aligned push:
  - push pc = 0x1c000000, inst0 = 0xAAAA0001, inst1 = 0xBBBB0002, pc_next = 0x1c000100, taken = 1, id_allowin = 0 -> next cycle count = 2;
  - out_pc0 = 0x1c000000, out_taken0 = 0, out_pc_next0 = 0x1c000004;
  - out_pc1 = 0x1c000004, out_inst1 = 0xBBBB0002, out_taken1 = 1, out_pc_next1 = 0x1c000100.
- Single-slot packets:
  - push pc = 0x1c000004 -> 1 slot, inst = in_inst1, out_valid1 = 0;
  - push with excp_flag = 2'b01, exception = 7'h08 -> 1 slot;
  - when that slot is head, out_valid1 = 0 even with count >= 2.
- Fill to threshold (DEPTH = 8, SPACE_TH = 6, id_allowin = 0):
  - after 1 aligned push, free = 6 -> space_ok = 1;
  - after 2, free = 4 -> space_ok = 0, nearly_full = 1;
  - after 3, free = 2 -> nearly_full = 1, in_allowin = 1;
  - after 4, free = 0 -> in_allowin = 0, nearly_full = 0; a further in_valid is ignored.
- Concurrent push and pop with wrap:
  - preload head = tail = 7, count = 0;
  - push aligned pair -> writes slots 7 and 0, tail = 1;
  - next cycle push + id_allowin -> pops 2, pushes 2, count stays 2, PCs remain in order.
- Flush:
  - flush with count = 6 coinciding with in_valid and id_allowin -> next cycle count = 0, out_valid0 = 0, in_allowin = 1, space_ok = 1.

Source files
------------

// File: rtl/inst_fifo.sv
// Instruction buffer between IF1 and decode: accepts 1-2 instruction fetch packets per cycle and
// presents up to two in-order instructions to decode. Fetch exceptions always issue alone.
module inst_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned SPACE_TH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_allowin,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_next,
  input  logic        in_pc_taken,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic [31:0] in_badv,
  input  logic [6:0]  in_exception,
  input  logic [1:0]  in_excp_flag,
  output logic        space_ok,
  output logic        nearly_full,
  input  logic        id_allowin,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_pc_next0,
  output logic [31:0] out_pc_next1,
  output logic        out_taken0,
  output logic        out_taken1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_badv0,
  output logic [31:0] out_badv1,
  output logic [6:0]  out_exception0,
  output logic [6:0]  out_exception1,
  output logic [1:0]  out_excp_flag0,
  output logic [1:0]  out_excp_flag1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [31:0] pc_q      [DEPTH];
  logic [31:0] pc_next_q [DEPTH];
  logic        taken_q   [DEPTH];
  logic [31:0] inst_q    [DEPTH];
  logic [31:0] badv_q    [DEPTH];
  logic [6:0]  exc_q     [DEPTH];
  logic [1:0]  flag_q    [DEPTH];

  ptr_t head_q, head_d, tail_q, tail_d, head1, tail1;
  cnt_t count_q, count_d, free_w, push_n, pop_n;

  logic        push, wr_en, single;
  logic [31:0] pc_plus4, a_inst, a_pc_next;
  logic        a_taken;

  assign head1    = head_q + ptr_t'(1);
  assign tail1    = tail_q + ptr_t'(1);
  assign pc_plus4 = in_pc + 32'd4;

  // Flags come from the registered count only, so a same-cycle pop never widens the window.
  assign free_w      = cnt_t'(DEPTH) - count_q;
  assign in_allowin  = free_w >= cnt_t'(2);
  assign space_ok    = free_w >= cnt_t'(SPACE_TH);
  assign nearly_full = in_allowin && !space_ok;

  assign out_valid0 = count_q != '0;
  assign out_valid1 = (count_q >= cnt_t'(2)) && (flag_q[head_q] == 2'b00);

  assign push   = in_valid && in_allowin;
  assign wr_en  = push && !flush;
  // Odd-word PC or a fetch exception carries only one meaningful instruction.
  assign single = in_pc[2] || (in_excp_flag != 2'b00);

  assign a_inst    = in_pc[2] ? in_inst1 : in_inst0;
  assign a_pc_next = single ? in_pc_next : pc_plus4;
  assign a_taken   = single ? in_pc_taken : 1'b0;

  always_comb begin
    push_n = '0;
    pop_n  = '0;
    if (push) push_n = single ? cnt_t'(1) : cnt_t'(2);
    if (id_allowin) pop_n = cnt_t'(out_valid0) + cnt_t'(out_valid1);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + ptr_t'(pop_n);
      tail_d  = tail_q + ptr_t'(push_n);
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        pc_next_q[i] <= '0;
        taken_q[i]   <= 1'b0;
        inst_q[i]    <= INST_NOP;
        badv_q[i]    <= '0;
        exc_q[i]     <= '0;
        flag_q[i]    <= '0;
      end
    end else if (wr_en) begin
      pc_q[tail_q]      <= in_pc;
      pc_next_q[tail_q] <= a_pc_next;
      taken_q[tail_q]   <= a_taken;
      inst_q[tail_q]    <= a_inst;
      badv_q[tail_q]    <= in_badv;
      exc_q[tail_q]     <= in_exception;
      flag_q[tail_q]    <= in_excp_flag;
      if (!single) begin
        pc_q[tail1]      <= pc_plus4;
        pc_next_q[tail1] <= in_pc_next;
        taken_q[tail1]   <= in_pc_taken;
        inst_q[tail1]    <= in_inst1;
        badv_q[tail1]    <= '0;
        exc_q[tail1]     <= '0;
        flag_q[tail1]    <= '0;
      end
    end
  end

  always_comb begin
    out_pc0        = pc_q[head_q];
    out_pc_next0   = pc_next_q[head_q];
    out_taken0     = taken_q[head_q];
    out_inst0      = inst_q[head_q];
    out_badv0      = badv_q[head_q];
    out_exception0 = exc_q[head_q];
    out_excp_flag0 = flag_q[head_q];
    out_pc1        = pc_q[head1];
    out_pc_next1   = pc_next_q[head1];
    out_taken1     = taken_q[head1];
    out_inst1      = inst_q[head1];
    out_badv1      = badv_q[head1];
    out_exception1 = exc_q[head1];
    out_excp_flag1 = flag_q[head1];
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: a queue of expected slots is filled as packets are accepted and
// compared against both read slots and the back-pressure flags after every clock.
module tb_inst_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_allowin;
  logic [31:0] in_pc = '0, in_pc_next = '0, in_inst0 = '0, in_inst1 = '0, in_badv = '0;
  logic        in_pc_taken = 1'b0;
  logic [6:0]  in_exception = '0;
  logic [1:0]  in_excp_flag = '0;
  logic        space_ok, nearly_full;
  logic        id_allowin = 1'b0;
  logic        out_valid0, out_valid1, out_taken0, out_taken1;
  logic [31:0] out_pc0, out_pc1, out_pc_next0, out_pc_next1;
  logic [31:0] out_inst0, out_inst1, out_badv0, out_badv1;
  logic [6:0]  out_exception0, out_exception1;
  logic [1:0]  out_excp_flag0, out_excp_flag1;

  inst_fifo #(.DEPTH(8), .SPACE_TH(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_pc(in_pc), .in_pc_next(in_pc_next),
    .in_pc_taken(in_pc_taken), .in_inst0(in_inst0), .in_inst1(in_inst1), .in_badv(in_badv),
    .in_exception(in_exception), .in_excp_flag(in_excp_flag),
    .space_ok(space_ok), .nearly_full(nearly_full), .id_allowin(id_allowin),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_pc_next0(out_pc_next0),
    .out_pc_next1(out_pc_next1), .out_taken0(out_taken0), .out_taken1(out_taken1),
    .out_inst0(out_inst0), .out_inst1(out_inst1), .out_badv0(out_badv0), .out_badv1(out_badv1),
    .out_exception0(out_exception0), .out_exception1(out_exception1),
    .out_excp_flag0(out_excp_flag0), .out_excp_flag1(out_excp_flag1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        taken;
    logic [31:0] inst;
    logic [31:0] badv;
    logic [6:0]  exc;
    logic [1:0]  flag;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input ent_t e, input logic [31:0] pc,
                          input logic [31:0] pnext, input logic tk, input logic [31:0] inst,
                          input logic [31:0] badv, input logic [6:0] exc, input logic [1:0] flag);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_pc_next"}, pnext, e.pc_next);
    chk({tag, "_taken"}, 32'(tk), 32'(e.taken));
    chk({tag, "_inst"}, inst, e.inst);
    chk({tag, "_badv"}, badv, e.badv);
    chk({tag, "_exc"}, 32'(exc), 32'(e.exc));
    chk({tag, "_flag"}, 32'(flag), 32'(e.flag));
  endtask

  task automatic check_out();
    int sz;
    int free;
    sz   = q.size();
    free = 8 - sz;
    chk("valid0", 32'(out_valid0), 32'(sz >= 1));
    chk("valid1", 32'(out_valid1), 32'(sz >= 2 && q[0].flag == 2'b00));
    chk("allowin", 32'(in_allowin), 32'(free >= 2));
    chk("space_ok", 32'(space_ok), 32'(free >= 6));
    chk("nearly_full", 32'(nearly_full), 32'(free >= 2 && free < 6));
    if (sz >= 1) chk_slot("slot0", q[0], out_pc0, out_pc_next0, out_taken0, out_inst0,
                          out_badv0, out_exception0, out_excp_flag0);
    if (sz >= 2) chk_slot("slot1", q[1], out_pc1, out_pc_next1, out_taken1, out_inst1,
                          out_badv1, out_exception1, out_excp_flag1);
  endtask

  // One clock: decide pop/accept from the model state, advance the model, then check.
  task automatic tick();
    ent_t a, b;
    int   m;
    bit   acc, single;
    m = 0;
    acc = 1'b0;
    single = in_pc[2] || (in_excp_flag != 2'b00);
    if (!flush) begin
      acc = in_valid && (8 - q.size()) >= 2;
      if (id_allowin && q.size() >= 1) m = (q.size() >= 2 && q[0].flag == 2'b00) ? 2 : 1;
    end
    a.pc      = in_pc;
    a.inst    = in_pc[2] ? in_inst1 : in_inst0;
    a.badv    = in_badv;
    a.exc     = in_exception;
    a.flag    = in_excp_flag;
    a.pc_next = single ? in_pc_next : in_pc + 32'd4;
    a.taken   = single ? in_pc_taken : 1'b0;
    b.pc      = in_pc + 32'd4;
    b.inst    = in_inst1;
    b.badv    = '0;
    b.exc     = '0;
    b.flag    = '0;
    b.pc_next = in_pc_next;
    b.taken   = in_pc_taken;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      for (int i = 0; i < m; i++) void'(q.pop_front());
      if (acc) begin
        q.push_back(a);
        if (!single) q.push_back(b);
      end
    end
    #1;
    check_out();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] flag, input logic [6:0] exc,
                       input logic tk);
    in_valid     = v;
    in_pc        = pc;
    in_pc_next   = pc + 32'h100;
    in_pc_taken  = tk;
    in_inst0     = i0;
    in_inst1     = i1;
    in_excp_flag = flag;
    in_exception = exc;
    in_badv      = (flag != 2'b00) ? pc : 32'h0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_out();
    chk("rst_inst_nop", out_inst0, 32'h0340_0000);
    chk("rst_pc", out_pc0, 32'h0);

    // Fill to 5 then hit reset asynchronously between edges
    drive(1, 32'h1c00_0000, 32'h1111_0001, 32'h1111_0002, 2'b00, 7'h0, 1); tick();
    drive(1, 32'h1c00_0008, 32'h1111_0003, 32'h1111_0004, 2'b00, 7'h0, 0); tick();
    drive(1, 32'h1c00_0014, 32'h1111_0005, 32'h1111_0006, 2'b00, 7'h0, 1); tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid0", 32'(out_valid0), 32'h0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_out();

    // Odd-word packet: one slot, taken from in_inst1
    drive(1, 32'h1c00_0004, 32'hDEAD_0000, 32'hCCCC_0003, 2'b00, 7'h0, 1); tick();
    chk("single_inst", out_inst0, 32'hCCCC_0003);
    chk("single_valid1", 32'(out_valid1), 32'h0);
    in_valid = 1'b0; id_allowin = 1'b1; tick(); id_allowin = 1'b0;

    // Aligned pair, then fill to full with decode stalled
    drive(1, 32'h1c00_0000, 32'hAAAA_0001, 32'hBBBB_0002, 2'b00, 7'h0, 1); tick();
    chk("al_pc0", out_pc0, 32'h1c00_0000);
    chk("al_taken0", 32'(out_taken0), 32'h0);
    chk("al_pc_next0", out_pc_next0, 32'h1c00_0004);
    chk("al_pc1", out_pc1, 32'h1c00_0004);
    chk("al_inst1", out_inst1, 32'hBBBB_0002);
    chk("al_taken1", 32'(out_taken1), 32'h1);
    chk("al_pc_next1", out_pc_next1, 32'h1c00_0100);
    chk("fill1_space_ok", 32'(space_ok), 32'h1);
    drive(1, 32'h1c00_0020, 32'h2222_0001, 32'h2222_0002, 2'b00, 7'h0, 0); tick();
    chk("fill2_space_ok", 32'(space_ok), 32'h0);
    chk("fill2_nearly_full", 32'(nearly_full), 32'h1);
    drive(1, 32'h1c00_0040, 32'h3333_0001, 32'h3333_0002, 2'b00, 7'h0, 1); tick();
    chk("fill3_nearly_full", 32'(nearly_full), 32'h1);
    chk("fill3_allowin", 32'(in_allowin), 32'h1);
    drive(1, 32'h1c00_0060, 32'h4444_0001, 32'h4444_0002, 2'b00, 7'h0, 0); tick();
    chk("full_allowin", 32'(in_allowin), 32'h0);
    chk("full_nearly_full", 32'(nearly_full), 32'h0);
    drive(1, 32'h1c00_0080, 32'h5555_0001, 32'h5555_0002, 2'b00, 7'h0, 1); tick();
    chk("full_ignored_pc0", out_pc0, 32'h1c00_0000);
    in_valid = 1'b0; id_allowin = 1'b1;
    repeat (4) tick();
    id_allowin = 1'b0;
    chk("drained_valid0", 32'(out_valid0), 32'h0);

    // Exception packet issues alone; this also walks head/tail to slot 7
    drive(1, 32'h1c00_1000, 32'h6666_0001, 32'h6666_0002, 2'b00, 7'h0, 0); tick();
    drive(1, 32'h1c00_1008, 32'h6666_0003, 32'h6666_0004, 2'b01, 7'h08, 1); tick();
    drive(1, 32'h1c00_1014, 32'h6666_0005, 32'h6666_0006, 2'b00, 7'h0, 0); tick();
    drive(1, 32'h1c00_1018, 32'h6666_0007, 32'h6666_0008, 2'b00, 7'h0, 1); tick();
    in_valid = 1'b0; id_allowin = 1'b1; tick();
    chk("excp_alone_valid1", 32'(out_valid1), 32'h0);
    chk("excp_code", 32'(out_exception0), 32'h08);
    repeat (3) tick();
    id_allowin = 1'b0;

    // Pair written across the wrap, then push and pop together
    drive(1, 32'h1c00_2000, 32'h7777_0001, 32'h7777_0002, 2'b00, 7'h0, 1); tick();
    chk("wrap_pc0", out_pc0, 32'h1c00_2000);
    chk("wrap_pc1", out_pc1, 32'h1c00_2004);
    drive(1, 32'h1c00_2008, 32'h7777_0003, 32'h7777_0004, 2'b00, 7'h0, 0);
    id_allowin = 1'b1; tick();
    chk("wrap_pp_pc0", out_pc0, 32'h1c00_2008);
    chk("wrap_pp_pc1", out_pc1, 32'h1c00_200c);
    chk("wrap_pp_valid1", 32'(out_valid1), 32'h1);

    // Flush at count 6 against a coincident push and pop
    id_allowin = 1'b0;
    drive(1, 32'h1c00_3000, 32'h8888_0001, 32'h8888_0002, 2'b00, 7'h0, 1); tick();
    drive(1, 32'h1c00_3008, 32'h8888_0003, 32'h8888_0004, 2'b00, 7'h0, 0); tick();
    flush = 1'b1; id_allowin = 1'b1;
    drive(1, 32'h1c00_3010, 32'h8888_0005, 32'h8888_0006, 2'b00, 7'h0, 1); tick();
    flush = 1'b0;
    chk("flush_valid0", 32'(out_valid0), 32'h0);
    chk("flush_allowin", 32'(in_allowin), 32'h1);
    chk("flush_space_ok", 32'(space_ok), 32'h1);

    id_allowin = 1'b0;
    drive(1, 32'h1c00_4000, 32'h9999_0001, 32'h9999_0002, 2'b00, 7'h0, 0); tick();
    in_valid = 1'b0; id_allowin = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
